// File: rtl/seg_scan.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds a packed BCD word and steps through digits with dead-time, range and leading-zero blanking.
module seg_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CntW-1:0] CntMax   = CntW'(DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);
    localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);

    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0][3:0]   active_q, active_d;
    logic [3:0]               num_q, num_d;
    logic [DIGITS-1:0]        sel_q, sel_d;
    logic                     fd_q, fd_d;

    logic                     cnt_wrap;
    logic                     idx_wrap;
    logic                     frame_end;
    logic [3:0]               cur_digit;
    logic                     past_blank;
    logic [DIGITS-1:0]        upper_zero;
    logic                     suppressed;
    logic                     visible;

    assign cnt_wrap  = (cnt_q == CntMax);
    assign idx_wrap  = (idx_q == IdxMax);
    assign frame_end = cnt_wrap && idx_wrap;

    // Scan counters and tear-free staging of the display word.
    always_comb begin
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d = load ? bcd_in : shadow_q;
        active_d = active_q;
        if (frame_end) begin
            active_d = load ? bcd_in : shadow_q;
        end
    end

    assign cur_digit = active_q[idx_q];

    if (BLANK == 0) begin : g_no_blank
        assign past_blank = 1'b1;
    end else begin : g_blank
        assign past_blank = (cnt_q >= CntBlank);
    end

    // upper_zero[i] is set when digits i..DIGITS-1 are all zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run           = run && (active_q[i] == 4'd0);
            upper_zero[i] = run;
        end
    end

    assign suppressed = lz_blank && (idx_q != '0) && upper_zero[idx_q];
    assign visible    = past_blank && (cur_digit <= 4'd9) && !suppressed;

    always_comb begin
        num_d = cur_digit;
        fd_d  = frame_end;
        sel_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            sel_d[i] = !(visible && (idx_q == IdxW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            num_q    <= '0;
            sel_q    <= '1;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            num_q    <= num_d;
            sel_q    <= sel_d;
            fd_q     <= fd_d;
        end
    end

    assign num        = num_q;
    assign dig_sel    = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: table-driven frames, load/reset corner sequences,
// and randomized traffic checked every cycle against a slot-arithmetic reference model.
module tb_seg_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 8;
    localparam int unsigned BLANK  = 2;
    localparam int unsigned FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  num;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset plus the staged and displayed words.
    int unsigned e = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;

    typedef struct {
        logic [15:0] bcd;
        logic        lz;
        logic [3:0]  mask;  // bit s set when digit s is expected to be enabled
    } vec_t;

    seg_scan #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .num       (num),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (e=%0d)", name, act, exp, e);
        end
    endtask

    // One clock edge; outputs are compared against the model, then the model advances.
    task automatic step();
        int         c;
        int         d;
        logic [3:0] ad;
        logic       sup;
        logic       vis;
        logic [3:0] x_num;
        logic [3:0] x_sel;
        logic       x_fd;
        logic       was_rst;
        logic       was_load;
        logic [15:0] was_bcd;
        was_rst  = rst;
        was_load = load;
        was_bcd  = bcd_in;
        if (rst) begin
            x_num = 4'd0;
            x_sel = 4'hF;
            x_fd  = 1'b0;
        end else begin
            c     = int'(e % DIV);
            d     = int'((e / DIV) % DIGITS);
            ad    = m_active[d*4 +: 4];
            sup   = lz_blank && (d != 0) && ((m_active >> (d * 4)) == 16'h0);
            vis   = (c >= int'(BLANK)) && (ad <= 4'd9) && !sup;
            x_num = ad;
            x_sel = vis ? ~(4'b0001 << d) : 4'hF;
            x_fd  = ((e % FRAME) == FRAME - 1);
        end
        @(posedge clk);
        #1;
        chk("num", num, x_num);
        chk("dig_sel", dig_sel, x_sel);
        chk("frame_done", frame_done, x_fd);
        if (was_rst) begin
            e        = 0;
            m_shadow = '0;
            m_active = '0;
        end else begin
            if (x_fd) m_active = was_load ? was_bcd : m_shadow;
            if (was_load) m_shadow = was_bcd;
            e++;
        end
    endtask

    // Advance until the next edge taken is the one at frame position t.
    task automatic run_to(input int unsigned t);
        while ((e % FRAME) != t) step();
    endtask

    task automatic load_word(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Expects to start at a frame boundary; checks each slot mid-way.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] mask);
        int         s;
        logic [3:0] sel;
        for (int k = 0; k < int'(FRAME); k++) begin
            step();
            if ((k % int'(DIV)) == 4) begin
                s   = k / int'(DIV);
                sel = mask[s] ? ~(4'b0001 << s) : 4'hF;
                chk("frame_num", num, v[s*4 +: 4]);
                chk("frame_sel", dig_sel, sel);
            end
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   on_cnt;
        vecs[0] = '{16'h1234, 1'b0, 4'b1111};
        vecs[1] = '{16'h0050, 1'b1, 4'b0011};
        vecs[2] = '{16'h0000, 1'b1, 4'b0001};
        vecs[3] = '{16'h0000, 1'b0, 4'b1111};
        vecs[4] = '{16'h9A07, 1'b0, 4'b1011};
        vecs[5] = '{16'h9A07, 1'b1, 4'b1011};
        vecs[6] = '{16'h0900, 1'b1, 4'b0111};
        vecs[7] = '{16'h1000, 1'b1, 4'b1111};
        vecs[8] = '{16'h00F0, 1'b1, 4'b0001};

        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = '0;
        lz_blank = 1'b0;

        // Reset held for three cycles, then digit 0 on for DIV-BLANK cycles.
        repeat (3) step();
        rst = 1'b0;
        on_cnt = 0;
        for (int k = 0; k < int'(DIV); k++) begin
            step();
            if (k == 1) chk("rel_edge1_sel", dig_sel, 4'b1111);
            if (k == 2) chk("rel_edge2_sel", dig_sel, 4'b1110);
            if (dig_sel == 4'b1110) on_cnt++;
        end
        chk("dig0_on_cycles", on_cnt, DIV - BLANK);

        // Table: load mid-frame, then verify the following frame.
        for (int i = 0; i < 9; i++) begin
            lz_blank = vecs[i].lz;
            run_to((i == 0) ? 5 : $urandom_range(0, FRAME - 2));
            load_word(vecs[i].bcd);
            run_to(0);
            check_frame(vecs[i].bcd, vecs[i].mask);
        end

        // Load at the boundary edge overrides an earlier load.
        lz_blank = 1'b0;
        run_to(10);
        load_word(16'h1111);
        run_to(FRAME - 1);
        load_word(16'h2222);
        check_frame(16'h2222, 4'b1111);

        // Two loads in one frame: last wins.
        run_to(5);
        load_word(16'h3333);
        run_to(20);
        load_word(16'h4444);
        run_to(0);
        check_frame(16'h4444, 4'b1111);

        // Reset during digit 2 slot.
        run_to(21);
        chk("pre_rst_sel", dig_sel, 4'b1011);
        rst = 1'b1;
        step();
        chk("mid_rst_sel", dig_sel, 4'b1111);
        chk("mid_rst_num", num, 4'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_sel", dig_sel, 4'b1110);
        chk("post_rst_num", num, 4'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int k = 0; k < 1500; k++) begin
            bcd_in = {$urandom_range(0, 15) < 6 ? 4'd0 : 4'($urandom_range(0, 15)),
                      $urandom_range(0, 15) < 6 ? 4'd0 : 4'($urandom_range(0, 15)),
                      $urandom_range(0, 15) < 6 ? 4'd0 : 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15))};
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
